// File: rtl/run_pair_detector.sv
// run_pair_detector: detects runs of RUN_LEN identical bits on a qualified
// serial input. Supports overlapping and non-overlapping detection, reports
// the bit value of the detected run and keeps a saturating detection count.
// RUN_LEN=2 with overlap=1 behaves like the classic 00/11 pair detector.
module run_pair_detector #(
  parameter int RUN_LEN = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             out,
  output logic             out_bit,
  output logic [CNT_W-1:0] det_count
);

  // Run counter must hold every value from 0 up to RUN_LEN inclusive.
  localparam int RCW = $clog2(RUN_LEN + 1);

  localparam logic [RCW-1:0]   RunLenVal = RCW'(RUN_LEN);
  localparam logic [RCW-1:0]   OneVal    = RCW'(1);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  logic [RCW-1:0]   r_runCnt;
  logic             r_lastBit;
  logic             r_haveLast;
  logic             r_out;
  logic             r_outBit;
  logic [CNT_W-1:0] r_detCount;

  logic             w_newRun;
  logic [RCW-1:0]   w_nxt;
  logic             w_hit;
  logic             w_cntSat;

  // Next run length for the incoming bit. A run restarts at 1 when there is
  // no previous bit, the bit changed, or a non-overlapping hit just cleared
  // the count. Otherwise the run grows, but never past RUN_LEN: in overlap
  // mode the counter parks at RUN_LEN so that every further identical bit
  // lands exactly on RUN_LEN again and produces another hit.
  always_comb begin
    w_newRun = 1'b0;
    w_nxt    = OneVal;
    w_hit    = 1'b0;
    w_cntSat = (r_detCount == CntMax);
    if (!r_haveLast || (in != r_lastBit) || (r_runCnt == '0)) begin
      w_newRun = 1'b1;
    end
    if (w_newRun) begin
      w_nxt = OneVal;
    end else if (r_runCnt >= RunLenVal) begin
      w_nxt = RunLenVal;
    end else begin
      w_nxt = r_runCnt + OneVal;
    end
    w_hit = in_valid && (w_nxt == RunLenVal);
  end

  // Run tracking state; only consumed (valid) bits move it, so idle cycles
  // leave a partial run intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_runCnt   <= '0;
      r_lastBit  <= 1'b0;
      r_haveLast <= 1'b0;
    end else if (in_valid) begin
      r_lastBit  <= in;
      r_haveLast <= 1'b1;
      if (w_hit) begin
        r_runCnt <= overlap ? RunLenVal : '0;
      end else begin
        r_runCnt <= w_nxt;
      end
    end
  end

  // Detection flag is a one-cycle registered pulse; the run's bit value is
  // captured on a hit and held until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out    <= 1'b0;
      r_outBit <= 1'b0;
    end else begin
      r_out <= w_hit;
      if (w_hit) begin
        r_outBit <= in;
      end
    end
  end

  // Saturating detection counter. A clear wins over a simultaneous hit, so
  // that hit is reported on out/out_bit but not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_detCount <= '0;
    end else if (cnt_clr) begin
      r_detCount <= '0;
    end else if (w_hit && !w_cntSat) begin
      r_detCount <= r_detCount + CNT_W'(1);
    end
  end

  assign out       = r_out;
  assign out_bit   = r_outBit;
  assign det_count = r_detCount;

endmodule

// File: tb/tb_run_pair_detector.sv
// tb_run_pair_detector: directed-vector bench for run_pair_detector. Three
// instances share one stimulus stream: RUN_LEN=2/CNT_W=8, RUN_LEN=3/CNT_W=8
// and RUN_LEN=2/CNT_W=2 (for counter saturation).
module tb_run_pair_detector;

  logic       clk;
  logic       reset;
  logic       inValid;
  logic       inBit;
  logic       overlap;
  logic       cntClr;

  logic       out2;
  logic       outBit2;
  logic [7:0] detCount2;
  logic       out3;
  logic       outBit3;
  logic [7:0] detCount3;
  logic       outC;
  logic       outBitC;
  logic [1:0] detCountC;

  int checks;
  int failures;

  run_pair_detector #(.RUN_LEN(2), .CNT_W(8)) dut2 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in(inBit),
    .overlap(overlap), .cnt_clr(cntClr),
    .out(out2), .out_bit(outBit2), .det_count(detCount2)
  );

  run_pair_detector #(.RUN_LEN(3), .CNT_W(8)) dut3 (
    .clk(clk), .reset(reset), .in_valid(inValid), .in(inBit),
    .overlap(overlap), .cnt_clr(cntClr),
    .out(out3), .out_bit(outBit3), .det_count(detCount3)
  );

  run_pair_detector #(.RUN_LEN(2), .CNT_W(2)) dutC (
    .clk(clk), .reset(reset), .in_valid(inValid), .in(inBit),
    .overlap(overlap), .cnt_clr(cntClr),
    .out(outC), .out_bit(outBitC), .det_count(detCountC)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one edge worth of inputs on the falling edge, then return 1 unit
  // after the rising edge so outputs can be sampled away from the edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic b,
                               input logic ov, input logic clr);
    @(negedge clk);
    reset   = rst;
    inValid = v;
    inBit   = b;
    overlap = ov;
    cntClr  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [5:0] legacyBits;
    logic [5:0] legacyOut;
    logic [4:0] nonOvOut;
    logic [5:0] gapValid;
    logic [5:0] gapOut;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    inValid  = 1'b0;
    inBit    = 1'b0;
    overlap  = 1'b0;
    cntClr   = 1'b0;

    // Reset state
    doReset();
    checkOutput("reset_out", int'(out2), 0);
    checkOutput("reset_outbit", int'(outBit2), 0);
    checkOutput("reset_count", int'(detCount2), 0);

    // Legacy pairs: bits 1,1,1,0,0,1 with overlap, RUN_LEN=2
    legacyBits = 6'b100111;
    legacyOut  = 6'b010110;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, legacyBits[i], 1'b1, 1'b0);
      checkOutput($sformatf("legacy_out_%0d", i), int'(out2), int'(legacyOut[i]));
      if (i == 1) checkOutput("legacy_outbit_b2", int'(outBit2), 1);
      if (i == 2) checkOutput("legacy_outbit_b3", int'(outBit2), 1);
      if (i == 4) checkOutput("legacy_outbit_b5", int'(outBit2), 0);
    end
    checkOutput("legacy_outbit_hold", int'(outBit2), 0);
    checkOutput("legacy_count", int'(detCount2), 3);

    // Non-overlap, RUN_LEN=2: five zeros hit after bits 2 and 4
    doReset();
    nonOvOut = 5'b01010;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("nonov_out_%0d", i), int'(out2), int'(nonOvOut[i]));
    end
    checkOutput("nonov_count", int'(detCount2), 2);
    checkOutput("nonov_outbit", int'(outBit2), 0);

    // Gapped run, RUN_LEN=3: 1,idle,1,idle,idle,1
    doReset();
    gapValid = 6'b100101;
    gapOut   = 6'b100000;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, gapValid[i], 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("gap_out_%0d", i), int'(out3), int'(gapOut[i]));
    end
    checkOutput("gap_outbit", int'(outBit3), 1);
    checkOutput("gap_count", int'(detCount3), 1);

    // Reset mid-run, RUN_LEN=3; valid 1 presented during reset is ignored
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("midrst_out_rst", int'(out3), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("midrst_out_a", int'(out3), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("midrst_out_b", int'(out3), 0);
    checkOutput("midrst_count_pre", int'(detCount3), 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("midrst_out_hit", int'(out3), 1);
    checkOutput("midrst_count", int'(detCount3), 1);

    // Counter limits: CNT_W=2, overlap, seven ones -> six hits, saturate at 3
    doReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      if (i == 2) checkOutput("sat_count_b3", int'(detCountC), 2);
      if (i == 3) checkOutput("sat_count_b4", int'(detCountC), 3);
    end
    checkOutput("sat_out_b7", int'(outC), 1);
    checkOutput("sat_count_b7", int'(detCountC), 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("clr_hit_out", int'(outC), 1);
    checkOutput("clr_hit_outbit", int'(outBitC), 1);
    checkOutput("clr_hit_count", int'(detCountC), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("idle_out", int'(outC), 0);

    // Alternating input 0,1,0,1... for 20 edges
    doReset();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, logic'(i % 2), 1'b1, 1'b0);
      checkOutput($sformatf("alt_out_%0d", i), int'(out2), 0);
    end
    checkOutput("alt_count", int'(detCount2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
